// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM frame scheduler: FSM states, default timing, width math.
// SERVO_CLAMP_EN: when defined, commanded pulse widths saturate at the MAX_US limit.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DEF_TICK_DIV = 100;
    localparam int DEF_FRAME_US = 20000;
    localparam int DEF_MIN_US   = 1000;
    localparam int DEF_STEP_US  = 4;
    localparam int DEF_MAX_US   = 2000;
    localparam int DEF_RESET_US = 1500;
    localparam int DEF_POS_W    = 8;

`ifdef SERVO_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    // Pulse width in microseconds for a position word, held in a 16-bit register.
    function automatic logic [15:0] calc_width(input int pos, input int min_us,
                                               input int step_us, input int max_us);
        int w;
        w = min_us + pos * step_us;
        if (CLAMP_EN && (w > max_us)) begin
            w = max_us;
        end
        return w[15:0];
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Microsecond tick generator: one-cycle tick every TICK_DIV cycles of Clck_in.
// Latency: tick asserts TICK_DIV cycles after clear drops. Backpressure: none; clear restarts the count.
// Synchronous clear holds the counter at zero for as long as it is asserted.
module servo_tick_gen
    import servo_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic Clck_in,
    input  logic reset_Clock,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] tick_cnt;
    logic             wrap;

    assign wrap = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign tick = wrap;

    always_ff @(posedge Clck_in) begin
        if (reset_Clock || clear) begin
            tick_cnt <= '0;
        end else if (wrap) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_pwm_sched.sv
// Servo PWM frame scheduler: one pulse per frame, width from the last command applied at a frame boundary.
// Latency: outputs follow the FSM by one register stage; a command accepted in frame k drives frame k+1.
// Backpressure: single pending slot, pos_ready = slot empty. Width saturation under SERVO_CLAMP_EN.
module servo_pwm_sched
    import servo_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int FRAME_US = DEF_FRAME_US,
    parameter int MIN_US   = DEF_MIN_US,
    parameter int STEP_US  = DEF_STEP_US,
    parameter int MAX_US   = DEF_MAX_US,
    parameter int RESET_US = DEF_RESET_US,
    parameter int POS_W    = DEF_POS_W
) (
    input  logic             Clck_in,
    input  logic             reset_Clock,
    input  logic             enable,
    input  logic             pos_valid,
    input  logic [POS_W-1:0] pos_data,
    output logic             pos_ready,
    output logic             pwm_out,
    output logic             frame_start,
    output logic             busy
);

    state_t      state, state_nxt;
    logic [15:0] us_cnt;
    logic [15:0] active_us;
    logic [15:0] pend_us;
    logic        pend_valid;
    logic        first_q;
    logic        tick;
    logic        tick_clear;
    logic        start;
    logic        accept;
    logic        pulse_end;
    logic        frame_end;

    servo_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .Clck_in    (Clck_in),
        .reset_Clock(reset_Clock),
        .clear      (tick_clear),
        .tick       (tick)
    );

    assign pos_ready = !pend_valid;
    assign accept    = pos_valid && pos_ready;
    assign pulse_end = tick && ((us_cnt + 16'd1) == active_us);
    assign frame_end = tick && (us_cnt == 16'(FRAME_US - 1));

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        case (state)
            IDLE:    start = enable;
            HIGH:    if (pulse_end) state_nxt = LOW;
            LOW: begin
                if (frame_end) begin
                    if (enable) start = 1'b1;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            state_nxt = HIGH;
        end
        tick_clear = (state == IDLE) || start;
    end

    always_ff @(posedge Clck_in) begin
        if (reset_Clock) begin
            state       <= IDLE;
            us_cnt      <= '0;
            active_us   <= 16'(RESET_US);
            pend_us     <= '0;
            pend_valid  <= 1'b0;
            first_q     <= 1'b0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            first_q     <= start;
            frame_start <= first_q;
            pwm_out     <= (state == HIGH);
            busy        <= (state != IDLE);

            if (start || (state_nxt == IDLE)) begin
                us_cnt <= '0;
            end else if (tick) begin
                us_cnt <= us_cnt + 16'd1;
            end

            if (start && pend_valid) begin
                active_us <= pend_us;
            end

            // Accept needs an empty slot, so it can never collide with a load at frame start.
            if (accept) begin
                pend_valid <= 1'b1;
                pend_us    <= calc_width(int'(pos_data), MIN_US, STEP_US, MAX_US);
            end else if (start) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_sched.sv
// Randomized scoreboard bench for servo_pwm_sched, plus a STEP_US=0 instance for the full-range position check.
// Frame-level reference model predicts widths, periods, pos_ready, busy and frame_start.
module tb_servo_pwm_sched;

    localparam int TICK_DIV = 4;
    localparam int FRAME_US = 50;
    localparam int MIN_US   = 10;
    localparam int STEP_US  = 1;
    localparam int MAX_US   = 20;
    localparam int RESET_US = 15;
    localparam int POS_W    = 8;
    localparam int PERIOD   = FRAME_US * TICK_DIV;
`ifdef SERVO_CLAMP_EN
    localparam int POS_MAX  = 255;
`else
    localparam int POS_MAX  = (FRAME_US - 1 - MIN_US) / STEP_US;
`endif

    logic             Clck_in     = 1'b0;
    logic             reset_Clock = 1'b1;
    logic             enable      = 1'b0;
    logic             pos_valid   = 1'b0;
    logic [POS_W-1:0] pos_data    = '0;
    logic [POS_W-1:0] pos_data0   = '0;
    logic pos_ready, pwm_out, frame_start, busy;
    logic pos_ready0, pwm_out0, frame_start0, busy0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int w;
        int w0;
        bit per;
    } exp_t;
    exp_t exp_q[$];

    bit m_run   = 1'b0;
    bit m_pend  = 1'b0;
    bit m_busy  = 1'b0;
    bit m_fs    = 1'b0;
    bit m_st_q  = 1'b0;
    int m_cyc   = 0;
    int m_act   = RESET_US;
    int m_act0  = RESET_US;
    int m_pw    = 0;
    int m_pw0   = 0;

    servo_pwm_sched #(
        .TICK_DIV(TICK_DIV), .FRAME_US(FRAME_US), .MIN_US(MIN_US), .STEP_US(STEP_US),
        .MAX_US(MAX_US), .RESET_US(RESET_US), .POS_W(POS_W)
    ) u_dut (
        .Clck_in(Clck_in), .reset_Clock(reset_Clock), .enable(enable),
        .pos_valid(pos_valid), .pos_data(pos_data), .pos_ready(pos_ready),
        .pwm_out(pwm_out), .frame_start(frame_start), .busy(busy)
    );

    servo_pwm_sched #(
        .TICK_DIV(TICK_DIV), .FRAME_US(FRAME_US), .MIN_US(MIN_US), .STEP_US(0),
        .MAX_US(MAX_US), .RESET_US(RESET_US), .POS_W(POS_W)
    ) u_dut0 (
        .Clck_in(Clck_in), .reset_Clock(reset_Clock), .enable(enable),
        .pos_valid(pos_valid), .pos_data(pos_data0), .pos_ready(pos_ready0),
        .pwm_out(pwm_out0), .frame_start(frame_start0), .busy(busy0)
    );

    initial forever #5 Clck_in = ~Clck_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_width(input int pos, input int step);
        int w;
        w = MIN_US + pos * step;
`ifdef SERVO_CLAMP_EN
        if (w > MAX_US) w = MAX_US;
`endif
        return w;
    endfunction

    // Reference model: frames are PERIOD cycles long, restarted while enable is high.
    initial begin : model
        bit acc, st, was_run;
        forever begin
            @(posedge Clck_in);
            if (reset_Clock) begin
                m_run = 0; m_pend = 0; m_busy = 0; m_fs = 0; m_st_q = 0; m_cyc = 0;
                m_act = RESET_US; m_act0 = RESET_US;
                exp_q.delete();
            end else begin
                acc     = pos_valid && !m_pend;
                m_busy  = m_run;
                m_fs    = m_st_q;
                was_run = m_run;
                st      = 0;
                if (m_run) begin
                    m_cyc++;
                    if (m_cyc == PERIOD) begin
                        if (enable) st = 1;
                        else        m_run = 0;
                    end
                end else if (enable) begin
                    st = 1;
                end
                if (st) begin
                    if (m_pend) begin
                        m_act  = m_pw;
                        m_act0 = m_pw0;
                        m_pend = 0;
                    end
                    exp_q.push_back('{w: m_act * TICK_DIV, w0: m_act0 * TICK_DIV, per: was_run});
                    m_run = 1;
                    m_cyc = 0;
                end
                m_st_q = st;
                if (acc) begin
                    m_pend = 1;
                    m_pw   = ref_width(int'(pos_data), STEP_US);
                    m_pw0  = ref_width(int'(pos_data0), 0);
                end
            end
        end
    end

    initial begin : monitor
        bit   prev, prev0, cur_ok;
        int   hi, hi0, since;
        exp_t cur;
        prev = 0; prev0 = 0; cur_ok = 0; hi = 0; hi0 = 0; since = 0;
        forever begin
            @(negedge Clck_in);
            if (reset_Clock) begin
                prev = 0; prev0 = 0; cur_ok = 0; hi = 0; hi0 = 0; since = 0;
            end else begin
                chk("pos_ready", int'(pos_ready), int'(!m_pend));
                chk("pos_ready_step0", int'(pos_ready0), int'(!m_pend));
                chk("busy", int'(busy), int'(m_busy));
                chk("busy_step0", int'(busy0), int'(m_busy));
                chk("frame_start", int'(frame_start), int'(m_fs));
                chk("frame_start_step0", int'(frame_start0), int'(m_fs));
                since++;
                if (pwm_out && !prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: pwm_out rose with no frame predicted");
                        cur_ok = 0;
                    end else begin
                        cur    = exp_q.pop_front();
                        cur_ok = 1;
                        if (cur.per) chk("frame_period", since, PERIOD);
                    end
                    since = 0;
                    hi    = 1;
                end else if (pwm_out) begin
                    hi++;
                end else if (prev && cur_ok) begin
                    chk("pulse_width", hi, cur.w);
                end
                if (pwm_out0 && !prev0) begin
                    hi0 = 1;
                end else if (pwm_out0) begin
                    hi0++;
                end else if (prev0 && cur_ok) begin
                    chk("pulse_width_step0", hi0, cur.w0);
                end
                prev  = pwm_out;
                prev0 = pwm_out0;
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge Clck_in);
        #1;
    endtask

    // Hold the command on the bus until the model's slot is free, then let one edge take it.
    task automatic send(input int p, input int p0);
        bit ok;
        ok        = 0;
        pos_valid = 1'b1;
        pos_data  = POS_W'(p);
        pos_data0 = POS_W'(p0);
        for (int i = 0; i < 3 * PERIOD && !ok; i++) begin
            if (!m_pend) ok = 1;
            @(posedge Clck_in);
            #1;
        end
        pos_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: pos %0d not accepted within %0d cycles", p, 3 * PERIOD);
        end
    endtask

    task automatic wait_fs();
        bit found;
        found = 0;
        for (int i = 0; i < 3 * PERIOD && !found; i++) begin
            @(negedge Clck_in);
            if (frame_start) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_start_timeout: none within %0d cycles", 3 * PERIOD);
        end
    endtask

    initial begin : stim
        tick_n(3);
        @(negedge Clck_in);
        chk("reset_pwm_out", int'(pwm_out), 0);
        chk("reset_frame_start", int'(frame_start), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pos_ready", int'(pos_ready), 1);

        @(posedge Clck_in);
        #1;
        reset_Clock = 1'b0;
        enable      = 1'b1;
        @(negedge Clck_in);
        @(negedge Clck_in);
        chk("start_latency_pwm_low", int'(pwm_out), 0);
        @(negedge Clck_in);
        chk("start_latency_pwm_high", int'(pwm_out), 1);
        chk("start_latency_frame_start", int'(frame_start), 1);
        chk("start_latency_busy", int'(busy), 1);
        tick_n(3 * PERIOD);

        send(3, 3);
        tick_n(2 * PERIOD + 20);

        send(1, 1);
        send(7, 7);
        tick_n(3 * PERIOD);

        send(POS_MAX, 255);
        tick_n(2 * PERIOD + 10);

        wait_fs();
        tick_n(30);
        enable = 1'b0;
        tick_n(PERIOD + 20);
        @(negedge Clck_in);
        chk("idle_pwm_out", int'(pwm_out), 0);
        chk("idle_busy", int'(busy), 0);
        @(posedge Clck_in);
        #1;
        enable = 1'b1;

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                tick_n(int'($urandom_range(1, 400)));
                enable = 1'b1;
            end else begin
                tick_n(int'($urandom_range(0, 250)));
                send(int'($urandom_range(0, POS_MAX)), int'($urandom_range(0, 255)));
            end
        end
        tick_n(2 * PERIOD + 10);

        wait_fs();
        @(posedge Clck_in);
        #1;
        send(20, 20);
        tick_n(2);
        reset_Clock = 1'b1;
        @(posedge Clck_in);
        @(negedge Clck_in);
        chk("midframe_reset_pwm_out", int'(pwm_out), 0);
        chk("midframe_reset_pos_ready", int'(pos_ready), 1);
        @(posedge Clck_in);
        #1;
        reset_Clock = 1'b0;
        tick_n(3 * PERIOD);

        enable = 1'b0;
        tick_n(PERIOD + 20);
        @(negedge Clck_in);
        chk("final_queue_drained", exp_q.size(), 0);
        chk("final_pwm_out", int'(pwm_out), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
